// File: rtl/pipeline_pkg.sv
// Shared types for the RV32 pipeline registers: control bundle carried from decode to execute.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic [2:0]  funct3;
    } de_ctrl_t;

    localparam int unsigned DE_CTRL_W = $bits(de_ctrl_t);
    localparam de_ctrl_t    DE_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register slice with synchronous clear (dominant) and load enable.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register: freezes on hold, bubbles on stall/flush, counts bubbles.
module decode_execute_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_e,
    input  logic              stall,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] pc_plus4_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  de_ctrl_t          ctrl_d,
    output logic [DATA_W-1:0] pc_e,
    output logic [DATA_W-1:0] pc_plus4_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output de_ctrl_t          ctrl_e,
    output logic              valid_e,
    output logic              mem_read_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned        DP_W    = 5 * DATA_W;
    localparam int unsigned        CT_W    = DE_CTRL_W + 3 * REG_AW + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic            bubble_c;
    logic            load_c;
    de_ctrl_t        ctrl_in_c;
    logic [DP_W-1:0] dp_d;
    logic [DP_W-1:0] dp_q;
    logic [CT_W-1:0] ct_d;
    logic [CT_W-1:0] ct_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // flush overrides hold; stall only acts when not frozen
    assign bubble_c  = flush_e | (stall & ~hold_e);
    assign load_c    = ~hold_e;
    assign ctrl_in_c = valid_d ? ctrl_d : DE_CTRL_NOP;

    assign dp_d = {pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d};
    assign ct_d = {ctrl_in_c, rs1_d, rs2_d, rd_d, valid_d};

    pipe_reg #(.W(DP_W)) u_dp_reg (
        .clk   (clk),
        .en_i  (load_c),
        .clr_i (rst),
        .d_i   (dp_d),
        .q_o   (dp_q)
    );

    pipe_reg #(.W(CT_W)) u_ct_reg (
        .clk   (clk),
        .en_i  (load_c),
        .clr_i (rst | bubble_c),
        .d_i   (ct_d),
        .q_o   (ct_q)
    );

    assign {pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e} = dp_q;
    assign {ctrl_e, rs1_e, rs2_e, rd_e, valid_e}   = ct_q;
    assign mem_read_e = ctrl_e.mem_read;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed self-checking bench for decode_execute_reg (counter narrowed to 4 bits).
module tb_decode_execute_reg;
    import pipeline_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, hold_e, stall, flush_e, valid_d;
    logic [DATA_W-1:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    de_ctrl_t          ctrl_d;
    logic [DATA_W-1:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    de_ctrl_t          ctrl_e;
    logic              valid_e, mem_read_e;
    logic [CNT_W-1:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_execute_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hold_e(hold_e), .stall(stall), .flush_e(flush_e),
        .valid_d(valid_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d),
        .rd2_d(rd2_d), .imm_d(imm_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .ctrl_d(ctrl_d), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e),
        .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .ctrl_e(ctrl_e), .valid_e(valid_e), .mem_read_e(mem_read_e),
        .bubble_cnt(bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hold_e = 1'b0; stall = 1'b0; flush_e = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input de_ctrl_t c);
        valid_d = 1'b1; pc_d = pc; pc_plus4_d = pc + 32'd4;
        rd1_d = pc ^ 32'hA5A5_0000; rd2_d = pc ^ 32'h0000_5A5A; imm_d = 32'h10;
        rs1_d = rs1; rs2_d = rs2; rd_d = rd; ctrl_d = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold_e = 1'b0; flush_e = 1'b0; stall = 1'b0; valid_d = 1'b1;
        pc_d = $urandom; pc_plus4_d = $urandom; rd1_d = $urandom; rd2_d = $urandom;
        imm_d = $urandom; rs1_d = REG_AW'($urandom); rs2_d = REG_AW'($urandom);
        rd_d = REG_AW'($urandom); ctrl_d = de_ctrl_t'(DE_CTRL_W'($urandom) | 1);
        tick(); tick();
        total++; if (pc_e !== '0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_e); end
        total++; if (rd1_e !== '0 || imm_e !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", rd1_e, imm_e); end
        total++; if ({rs1_e, rs2_e, rd_e} !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {rs1_e, rs2_e, rd_e}); end
        total++; if (ctrl_e !== DE_CTRL_NOP || valid_e !== 1'b0) begin bad++; $display("FAIL reset_ctrl got=%h/%b exp=0/0", ctrl_e, valid_e); end
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        de_ctrl_t c;
        do_reset();
        c = DE_CTRL_NOP; c.reg_write = 1'b1; c.alu_ctrl = 4'h3;
        set_instr(32'h100, 5'd2, 5'd3, 5'd5, c);
        tick();
        total++; if (pc_e !== 32'h100 || pc_plus4_e !== 32'h104) begin bad++; $display("FAIL normal_pc got=%h/%h exp=100/104", pc_e, pc_plus4_e); end
        total++; if (rd_e !== 5'd5 || rs1_e !== 5'd2 || rs2_e !== 5'd3) begin bad++; $display("FAIL normal_regs got=%0d/%0d/%0d exp=5/2/3", rd_e, rs1_e, rs2_e); end
        total++; if (ctrl_e.reg_write !== 1'b1 || ctrl_e.alu_ctrl !== 4'h3 || valid_e !== 1'b1) begin bad++; $display("FAIL normal_ctrl got=%h/%b exp=reg_write,alu3/1", ctrl_e, valid_e); end
        total++; if (rd1_e !== 32'hA5A5_0100 || imm_e !== 32'h10) begin bad++; $display("FAIL normal_data got=%h/%h exp=a5a50100/10", rd1_e, imm_e); end
    endtask

    task automatic test_load_use();
        de_ctrl_t c;
        do_reset();
        c = DE_CTRL_NOP; c.reg_write = 1'b1; c.mem_read = 1'b1; c.result_src = RES_MEM; c.funct3 = 3'b010;
        set_instr(32'h200, 5'd1, 5'd0, 5'd5, c);
        tick();
        total++; if (mem_read_e !== 1'b1 || rd_e !== 5'd5) begin bad++; $display("FAIL lu_load got=%b/%0d exp=1/5", mem_read_e, rd_e); end
        c = DE_CTRL_NOP; c.reg_write = 1'b1;
        set_instr(32'h204, 5'd5, 5'd1, 5'd6, c);
        stall = 1'b1;
        tick();
        total++; if (valid_e !== 1'b0 || rd_e !== 5'd0 || ctrl_e !== DE_CTRL_NOP || rs1_e !== 5'd0) begin bad++; $display("FAIL lu_bubble got=v%b rd%0d ctrl%h rs1%0d exp=0/0/0/0", valid_e, rd_e, ctrl_e, rs1_e); end
        total++; if (bubble_cnt !== 4'd1 || mem_read_e !== 1'b0) begin bad++; $display("FAIL lu_cnt got=%0d/%b exp=1/0", bubble_cnt, mem_read_e); end
        stall = 1'b0;
        tick();
        total++; if (rs1_e !== 5'd5 || rd_e !== 5'd6 || valid_e !== 1'b1 || pc_e !== 32'h204) begin bad++; $display("FAIL lu_replay got=rs1 %0d rd %0d v%b pc%h exp=5/6/1/204", rs1_e, rd_e, valid_e, pc_e); end
        total++; if (bubble_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt_after got=%0d exp=1", bubble_cnt); end
    endtask

    task automatic test_hold();
        de_ctrl_t c;
        do_reset();
        c = DE_CTRL_NOP; c.reg_write = 1'b1; c.branch = 1'b1;
        set_instr(32'h300, 5'd8, 5'd9, 5'd7, c);
        tick();
        hold_e = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h400 + 32'(i * 4), 5'd10, 5'd11, 5'd12, DE_CTRL_NOP);
            tick();
            total++; if (pc_e !== 32'h300 || rd_e !== 5'd7 || valid_e !== 1'b1 || ctrl_e !== c) begin bad++; $display("FAIL hold_keep%0d got=pc%h rd%0d v%b exp=300/7/1", i, pc_e, rd_e, valid_e); end
            total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL hold_cnt%0d got=%0d exp=0", i, bubble_cnt); end
        end
        hold_e = 1'b0;
        tick();
        total++; if (valid_e !== 1'b0 || rd_e !== 5'd0 || bubble_cnt !== 4'd1) begin bad++; $display("FAIL hold_release got=v%b rd%0d cnt%0d exp=0/0/1", valid_e, rd_e, bubble_cnt); end
        stall = 1'b0;
    endtask

    task automatic test_flush();
        de_ctrl_t c;
        do_reset();
        c = DE_CTRL_NOP; c.reg_write = 1'b1; c.jump = 1'b1; c.result_src = RES_PC4;
        set_instr(32'h500, 5'd3, 5'd4, 5'd1, c);
        tick();
        flush_e = 1'b1; stall = 1'b1;
        tick();
        total++; if (valid_e !== 1'b0 || ctrl_e !== DE_CTRL_NOP || bubble_cnt !== 4'd1) begin bad++; $display("FAIL flush_stall got=v%b ctrl%h cnt%0d exp=0/0/1", valid_e, ctrl_e, bubble_cnt); end
        flush_e = 1'b0; stall = 1'b0;
        tick();
        total++; if (valid_e !== 1'b1 || rd_e !== 5'd1) begin bad++; $display("FAIL flush_reload got=v%b rd%0d exp=1/1", valid_e, rd_e); end
        flush_e = 1'b1; hold_e = 1'b1;
        tick();
        total++; if (valid_e !== 1'b0 || rd_e !== 5'd0 || rs1_e !== 5'd0 || rs2_e !== 5'd0 || ctrl_e !== DE_CTRL_NOP) begin bad++; $display("FAIL flush_hold got=v%b rd%0d rs%0d/%0d ctrl%h exp=all 0", valid_e, rd_e, rs1_e, rs2_e, ctrl_e); end
        total++; if (bubble_cnt !== 4'd2) begin bad++; $display("FAIL flush_hold_cnt got=%0d exp=2", bubble_cnt); end
        flush_e = 1'b0; hold_e = 1'b0;
    endtask

    task automatic test_invalid_d();
        de_ctrl_t c;
        do_reset();
        c = DE_CTRL_NOP; c.reg_write = 1'b1; c.mem_write = 1'b1; c.mem_read = 1'b1;
        set_instr(32'h600, 5'd2, 5'd3, 5'd4, c);
        valid_d = 1'b0;
        tick();
        total++; if (ctrl_e !== DE_CTRL_NOP || valid_e !== 1'b0 || mem_read_e !== 1'b0) begin bad++; $display("FAIL invalid_ctrl got=%h/%b/%b exp=0/0/0", ctrl_e, valid_e, mem_read_e); end
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL invalid_cnt got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        set_instr(32'h700, 5'd1, 5'd2, 5'd3, DE_CTRL_NOP);
        stall = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            total++; if (bubble_cnt !== exp_cnt) begin bad++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, bubble_cnt, exp_cnt); end
        end
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", bubble_cnt); end
        rst = 1'b1; hold_e = 1'b1;
        tick();
        total++; if (bubble_cnt !== 4'd0 || valid_e !== 1'b0 || pc_e !== '0) begin bad++; $display("FAIL sat_reset got=cnt%0d v%b pc%h exp=0/0/0", bubble_cnt, valid_e, pc_e); end
        rst = 1'b0; hold_e = 1'b0; stall = 1'b0;
        tick();
        total++; if (valid_e !== 1'b1 || pc_e !== 32'h700 || bubble_cnt !== 4'd0) begin bad++; $display("FAIL sat_resume got=v%b pc%h cnt%0d exp=1/700/0", valid_e, pc_e, bubble_cnt); end
    endtask

    initial begin
        rst = 1'b1; hold_e = 1'b0; stall = 1'b0; flush_e = 1'b0; valid_d = 1'b0;
        pc_d = '0; pc_plus4_d = '0; rd1_d = '0; rd2_d = '0; imm_d = '0;
        rs1_d = '0; rs2_d = '0; rd_d = '0; ctrl_d = DE_CTRL_NOP;
        test_reset();
        test_normal();
        test_load_use();
        test_hold();
        test_flush();
        test_invalid_d();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
